// File: rtl/snd_cmd_mailbox.sv
// Main-to-sound command mailbox: CHANNELS independent FIFOs drained by the sound CPU,
// with per-channel overflow flags, optional overwrite-oldest and a level IRQ.
module snd_cmd_mailbox #(
   parameter int CHANNELS = 1,
   parameter int DEPTH = 4,
   parameter int W = 8,
   parameter int OVERWRITE = 0,
   parameter logic [CHANNELS-1:0] IRQ_MASK = '1,
   parameter logic [W-1:0] FILL = W'(8'hFF),
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int PW = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                main_wr,
   input  logic [CW-1:0]       main_ch,
   input  logic [W-1:0]        main_din,
   output logic [CHANNELS-1:0] main_full,
   input  logic                snd_rd,
   input  logic [CW-1:0]       snd_ch,
   output logic [W-1:0]        snd_dout,
   output logic                snd_valid,
   output logic [CHANNELS-1:0] snd_empty,
   output logic [CHANNELS-1:0] ovf,
   input  logic                ovf_clr,
   output logic                irq_n
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]        mem [CHANNELS][DEPTH];
   logic [PW-1:0]       wptr [CHANNELS];
   logic [PW-1:0]       rptr [CHANNELS];
   logic [PW-1:0]       count [CHANNELS];
   logic [PW-1:0]       wptr_next [CHANNELS];
   logic [PW-1:0]       rptr_next [CHANNELS];
   logic [PW-1:0]       count_next [CHANNELS];
   logic [CHANNELS-1:0] store;
   logic [CHANNELS-1:0] ovf_set;
   logic [CHANNELS-1:0] full_next;
   logic [CHANNELS-1:0] empty_next;
   logic [W-1:0]        rd_data;
   logic                rd_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A read in the same cycle frees a slot, so a full queue then accepts the write without overflow.
   always_comb begin
      store      = '0;
      ovf_set    = '0;
      full_next  = '0;
      empty_next = '0;
      rd_data    = FILL;
      rd_ok      = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         logic wr_hit, do_rd, full_now, discard, grow;
         wr_hit   = main_wr && (main_ch == CW'(c));
         full_now = (count[c] == PW'(DEPTH));
         do_rd    = snd_rd && (snd_ch == CW'(c)) && (count[c] != '0);
         store[c]   = wr_hit && (!full_now || do_rd || (OVERWRITE != 0));
         discard    = wr_hit && full_now && !do_rd && (OVERWRITE != 0);
         ovf_set[c] = wr_hit && full_now && !do_rd;
         grow       = store[c] && !discard;
         wptr_next[c]  = store[c] ? ptr_inc(wptr[c]) : wptr[c];
         rptr_next[c]  = (do_rd || discard) ? ptr_inc(rptr[c]) : rptr[c];
         count_next[c] = count[c];
         if (grow && !do_rd) begin
            count_next[c] = count[c] + 1'b1;
         end else if (!grow && do_rd) begin
            count_next[c] = count[c] - 1'b1;
         end
         full_next[c]  = (count_next[c] == PW'(DEPTH));
         empty_next[c] = (count_next[c] == '0);
         if (do_rd) begin
            rd_data = mem[c][rptr[c][IW-1:0]];
            rd_ok   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (store[c]) begin
            mem[c][wptr[c][IW-1:0]] <= main_din;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            wptr[c]  <= '0;
            rptr[c]  <= '0;
            count[c] <= '0;
         end
         main_full <= '0;
         snd_empty <= '1;
         snd_dout  <= FILL;
         snd_valid <= 1'b0;
         ovf       <= '0;
         irq_n     <= 1'b1;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            wptr[c]  <= wptr_next[c];
            rptr[c]  <= rptr_next[c];
            count[c] <= count_next[c];
         end
         main_full <= full_next;
         snd_empty <= empty_next;
         if (snd_rd) begin
            snd_dout  <= rd_data;
            snd_valid <= rd_ok;
         end
         // Set wins over a simultaneous clear.
         ovf   <= (ovf_clr ? '0 : ovf) | ovf_set;
         irq_n <= ~|(~empty_next & IRQ_MASK);
      end
   end

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Bench for snd_cmd_mailbox: three configurations driven by directed scenarios and
// random traffic, checked against a queue-based reference model.
module tb_snd_cmd_mailbox;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr [3];
   logic [1:0] ch [3];
   logic [7:0] din [3];
   logic       rd [3];
   logic [1:0] rch [3];
   logic       clr [3];

   logic [7:0] dout [3];
   logic       valid [3];
   logic       irq [3];
   logic [1:0] full_a, empty_a, ovf_a;
   logic [0:0] full_b, empty_b, ovf_b;
   logic [2:0] full_c, empty_c, ovf_c;
   logic [3:0] fullv [3];
   logic [3:0] emptyv [3];
   logic [3:0] ovfv [3];

   int checks = 0;
   int failures = 0;

   // Instance configurations: A = 2ch/depth4/drop/mask01, B = legacy latch, C = 3ch/depth4/overwrite.
   int         nch [3] = '{2, 1, 3};
   int         dep [3] = '{4, 1, 4};
   int         owr [3] = '{0, 1, 1};
   logic [3:0] msk [3] = '{4'b0001, 4'b0001, 4'b0111};

   logic [7:0] mq [3][4][$];
   logic [3:0] ovf_m [3];
   logic [7:0] dout_m [3];
   logic       valid_m [3];

   always #5 clk = ~clk;

   snd_cmd_mailbox #(.CHANNELS(2), .DEPTH(4), .W(8), .OVERWRITE(0), .IRQ_MASK(2'b01), .FILL(8'hFF)) dut_a (
      .clk(clk), .rst(rst), .main_wr(wr[0]), .main_ch(ch[0][0:0]), .main_din(din[0]),
      .main_full(full_a), .snd_rd(rd[0]), .snd_ch(rch[0][0:0]), .snd_dout(dout[0]),
      .snd_valid(valid[0]), .snd_empty(empty_a), .ovf(ovf_a), .ovf_clr(clr[0]), .irq_n(irq[0]));

   snd_cmd_mailbox #(.CHANNELS(1), .DEPTH(1), .W(8), .OVERWRITE(1), .IRQ_MASK(1'b1), .FILL(8'hFF)) dut_b (
      .clk(clk), .rst(rst), .main_wr(wr[1]), .main_ch(ch[1][0:0]), .main_din(din[1]),
      .main_full(full_b), .snd_rd(rd[1]), .snd_ch(rch[1][0:0]), .snd_dout(dout[1]),
      .snd_valid(valid[1]), .snd_empty(empty_b), .ovf(ovf_b), .ovf_clr(clr[1]), .irq_n(irq[1]));

   snd_cmd_mailbox #(.CHANNELS(3), .DEPTH(4), .W(8), .OVERWRITE(1), .IRQ_MASK(3'b111), .FILL(8'hFF)) dut_c (
      .clk(clk), .rst(rst), .main_wr(wr[2]), .main_ch(ch[2]), .main_din(din[2]),
      .main_full(full_c), .snd_rd(rd[2]), .snd_ch(rch[2]), .snd_dout(dout[2]),
      .snd_valid(valid[2]), .snd_empty(empty_c), .ovf(ovf_c), .ovf_clr(clr[2]), .irq_n(irq[2]));

   assign fullv[0]  = {2'b0, full_a};
   assign fullv[1]  = {3'b0, full_b};
   assign fullv[2]  = {1'b0, full_c};
   assign emptyv[0] = {2'b0, empty_a};
   assign emptyv[1] = {3'b0, empty_b};
   assign emptyv[2] = {1'b0, empty_c};
   assign ovfv[0]   = {2'b0, ovf_a};
   assign ovfv[1]   = {3'b0, ovf_b};
   assign ovfv[2]   = {1'b0, ovf_c};

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 4; c++) mq[i][c].delete();
         ovf_m[i]   = 4'b0;
         dout_m[i]  = 8'hFF;
         valid_m[i] = 1'b0;
      end
   endtask

   // Reads see the queue as it was before this cycle's write; a read frees room for the write.
   task automatic model_step(input int i);
      if (rd[i]) begin
         if (int'(rch[i]) < nch[i] && mq[i][rch[i]].size() > 0) begin
            dout_m[i]  = mq[i][rch[i]].pop_front();
            valid_m[i] = 1'b1;
         end else begin
            dout_m[i]  = 8'hFF;
            valid_m[i] = 1'b0;
         end
      end
      if (clr[i]) ovf_m[i] = 4'b0;
      if (wr[i] && int'(ch[i]) < nch[i]) begin
         if (mq[i][ch[i]].size() < dep[i]) begin
            mq[i][ch[i]].push_back(din[i]);
         end else begin
            ovf_m[i][ch[i]] = 1'b1;
            if (owr[i] != 0) begin
               void'(mq[i][ch[i]].pop_front());
               mq[i][ch[i]].push_back(din[i]);
            end
         end
      end
   endtask

   function automatic logic [3:0] exp_full(input int i);
      logic [3:0] r = 4'b0;
      for (int c = 0; c < nch[i]; c++) r[c] = (mq[i][c].size() == dep[i]);
      return r;
   endfunction

   function automatic logic [3:0] exp_empty(input int i);
      logic [3:0] r = 4'b0;
      for (int c = 0; c < nch[i]; c++) r[c] = (mq[i][c].size() == 0);
      return r;
   endfunction

   function automatic logic exp_irq(input int i);
      logic r = 1'b1;
      for (int c = 0; c < nch[i]; c++) if (msk[i][c] && mq[i][c].size() > 0) r = 1'b0;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) model_step(i);
      for (int i = 0; i < 3; i++) begin
         wr[i]  = 1'b0;
         rd[i]  = 1'b0;
         clr[i] = 1'b0;
      end
   endtask

   task automatic wr_cmd(input int i, input logic [1:0] c, input logic [7:0] d);
      wr[i] = 1'b1; ch[i] = c; din[i] = d;
      tick();
   endtask

   task automatic rd_cmd(input int i, input logic [1:0] c);
      rd[i] = 1'b1; rch[i] = c;
      tick();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         wr[i] = 1'b0; ch[i] = 2'd0; din[i] = 8'h00;
         rd[i] = 1'b0; rch[i] = 2'd0; clr[i] = 1'b0;
      end
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         logic [3:0] all_empty;
         all_empty = 4'((1 << nch[i]) - 1);
         checks++;
         if (irq[i] !== 1'b1) begin failures++; $display("[TB] FAIL reset_irq inst%0d got %b expected 1", i, irq[i]); end
         checks++;
         if (emptyv[i] !== all_empty) begin failures++; $display("[TB] FAIL reset_empty inst%0d got %b expected %b", i, emptyv[i], all_empty); end
         checks++;
         if (dout[i] !== 8'hFF || valid[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_dout inst%0d got %h/%b expected FF/0", i, dout[i], valid[i]); end
         checks++;
         if (fullv[i] !== 4'b0 || ovfv[i] !== 4'b0) begin failures++; $display("[TB] FAIL reset_full_ovf inst%0d got %b/%b expected 0/0", i, fullv[i], ovfv[i]); end
      end
      rd_cmd(0, 2'd0);
      checks++;
      if (dout[0] !== 8'hFF || valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL empty_read got %h/%b expected FF/0", dout[0], valid[0]); end
   endtask

   task automatic test_fifo_order();
      logic [7:0] seq [4] = '{8'h8A, 8'h09, 8'h0F, 8'h01};
      wr_cmd(0, 2'd0, seq[0]);
      checks++;
      if (irq[0] !== 1'b0) begin failures++; $display("[TB] FAIL irq_after_write got %b expected 0", irq[0]); end
      for (int k = 1; k < 4; k++) wr_cmd(0, 2'd0, seq[k]);
      checks++;
      if (fullv[0] !== 4'b0001) begin failures++; $display("[TB] FAIL full_after_four got %b expected 0001", fullv[0]); end
      for (int k = 0; k < 4; k++) begin
         rd_cmd(0, 2'd0);
         checks++;
         if (dout[0] !== seq[k] || valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL fifo_read%0d got %h/%b expected %h/1", k, dout[0], valid[0], seq[k]); end
      end
      checks++;
      if (irq[0] !== 1'b1 || emptyv[0] !== 4'b0011) begin failures++; $display("[TB] FAIL drained got irq %b empty %b expected 1/0011", irq[0], emptyv[0]); end
   endtask

   task automatic test_overflow_drop();
      logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int k = 0; k < 4; k++) wr_cmd(0, 2'd0, seq[k]);
      wr_cmd(0, 2'd0, 8'h55);
      checks++;
      if (ovfv[0] !== 4'b0001) begin failures++; $display("[TB] FAIL ovf_drop got %b expected 0001", ovfv[0]); end
      clr[0] = 1'b1;
      wr_cmd(0, 2'd0, 8'h66);
      checks++;
      if (ovfv[0] !== 4'b0001) begin failures++; $display("[TB] FAIL ovf_set_wins got %b expected 0001", ovfv[0]); end
      for (int k = 0; k < 4; k++) begin
         rd_cmd(0, 2'd0);
         checks++;
         if (dout[0] !== seq[k] || valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL drop_read%0d got %h/%b expected %h/1", k, dout[0], valid[0], seq[k]); end
      end
      clr[0] = 1'b1;
      tick();
      checks++;
      if (ovfv[0] !== 4'b0) begin failures++; $display("[TB] FAIL ovf_clear got %b expected 0000", ovfv[0]); end
   endtask

   task automatic test_overwrite_latch();
      wr_cmd(1, 2'd0, 8'hFD);
      wr_cmd(1, 2'd0, 8'h01);
      checks++;
      if (ovfv[1] !== 4'b0001 || irq[1] !== 1'b0) begin failures++; $display("[TB] FAIL latch_ovf got ovf %b irq %b expected 0001/0", ovfv[1], irq[1]); end
      rd_cmd(1, 2'd0);
      checks++;
      if (dout[1] !== 8'h01 || valid[1] !== 1'b1 || irq[1] !== 1'b1) begin failures++; $display("[TB] FAIL latch_read got %h/%b irq %b expected 01/1 irq 1", dout[1], valid[1], irq[1]); end
      rd_cmd(1, 2'd0);
      checks++;
      if (dout[1] !== 8'hFF || valid[1] !== 1'b0) begin failures++; $display("[TB] FAIL latch_reread got %h/%b expected FF/0", dout[1], valid[1]); end
      clr[1] = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hAA};
      for (int k = 0; k < 4; k++) wr_cmd(0, 2'd0, seq[k]);
      rd[0] = 1'b1; rch[0] = 2'd0;
      wr_cmd(0, 2'd0, 8'hAA);
      checks++;
      if (dout[0] !== 8'hA1 || valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL full_rw_read got %h/%b expected A1/1", dout[0], valid[0]); end
      checks++;
      if (fullv[0] !== 4'b0001 || ovfv[0] !== 4'b0) begin failures++; $display("[TB] FAIL full_rw_flags got full %b ovf %b expected 0001/0000", fullv[0], ovfv[0]); end
      for (int k = 1; k < 5; k++) begin
         rd_cmd(0, 2'd0);
         checks++;
         if (dout[0] !== seq[k]) begin failures++; $display("[TB] FAIL full_rw_drain%0d got %h expected %h", k, dout[0], seq[k]); end
      end
      rd[0] = 1'b1; rch[0] = 2'd0;
      wr_cmd(0, 2'd0, 8'h33);
      checks++;
      if (dout[0] !== 8'hFF || valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL empty_rw_read got %h/%b expected FF/0", dout[0], valid[0]); end
      rd_cmd(0, 2'd0);
      checks++;
      if (dout[0] !== 8'h33 || valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL empty_rw_next got %h/%b expected 33/1", dout[0], valid[0]); end
   endtask

   task automatic test_mask_and_reset();
      wr_cmd(0, 2'd1, 8'h5A);
      checks++;
      if (irq[0] !== 1'b1 || emptyv[0] !== 4'b0001) begin failures++; $display("[TB] FAIL masked_ch got irq %b empty %b expected 1/0001", irq[0], emptyv[0]); end
      wr_cmd(0, 2'd0, 8'h5B);
      checks++;
      if (irq[0] !== 1'b0) begin failures++; $display("[TB] FAIL unmasked_ch got irq %b expected 0", irq[0]); end
      #3 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (irq[0] !== 1'b1 || emptyv[0] !== 4'b0011 || fullv[0] !== 4'b0) begin failures++; $display("[TB] FAIL async_reset_flags got irq %b empty %b full %b expected 1/0011/0000", irq[0], emptyv[0], fullv[0]); end
      checks++;
      if (dout[0] !== 8'hFF || valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_dout got %h/%b expected FF/0", dout[0], valid[0]); end
      #1 rst = 1'b0;
      rd_cmd(0, 2'd1);
      checks++;
      if (dout[0] !== 8'hFF || valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL lost_after_reset got %h/%b expected FF/0", dout[0], valid[0]); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 3; i++) begin
            wr[i]  = ($urandom_range(0, 99) < 50);
            ch[i]  = 2'($urandom_range(0, (i == 2) ? 3 : 1));
            din[i] = 8'($urandom);
            rd[i]  = ($urandom_range(0, 99) < 45);
            rch[i] = 2'($urandom_range(0, (i == 2) ? 3 : 1));
            clr[i] = ($urandom_range(0, 31) == 0);
         end
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout[i] !== dout_m[i] || valid[i] !== valid_m[i]) begin failures++; $display("[TB] FAIL rand_dout inst%0d cyc%0d got %h/%b expected %h/%b", i, n, dout[i], valid[i], dout_m[i], valid_m[i]); end
            checks++;
            if (fullv[i] !== exp_full(i)) begin failures++; $display("[TB] FAIL rand_full inst%0d cyc%0d got %b expected %b", i, n, fullv[i], exp_full(i)); end
            checks++;
            if (emptyv[i] !== exp_empty(i)) begin failures++; $display("[TB] FAIL rand_empty inst%0d cyc%0d got %b expected %b", i, n, emptyv[i], exp_empty(i)); end
            checks++;
            if (ovfv[i] !== ovf_m[i]) begin failures++; $display("[TB] FAIL rand_ovf inst%0d cyc%0d got %b expected %b", i, n, ovfv[i], ovf_m[i]); end
            checks++;
            if (irq[i] !== exp_irq(i)) begin failures++; $display("[TB] FAIL rand_irq inst%0d cyc%0d got %b expected %b", i, n, irq[i], exp_irq(i)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_overflow_drop();
      test_overwrite_latch();
      test_back_to_back();
      test_mask_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
